// File: rtl/wrr_arb_pkg.sv
// Shared types, defaults and helpers for the weighted round-robin arbiters.
package wrr_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int unsigned REQ_NUM_DEF = 8;
    localparam int unsigned CNT_W_DEF   = 4;
    localparam int unsigned OH_MAX      = 64;

    // Binary index of a one-hot vector (OR of set-bit indices; 0 for an all-zero vector).
    function automatic logic [31:0] onehot_to_bin(input logic [OH_MAX-1:0] oh);
        logic [31:0] idx;
        idx = '0;
        for (int i = 0; i < int'(OH_MAX); i++) begin
            if (oh[i]) idx = idx | 32'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_mask_pick.sv
// Masked lowest-index round-robin picker, shared by the arbiters in this codebase.
// Falls back to the unmasked request vector when no masked request is pending.
module rr_mask_pick #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] reqs,
    input  logic [N-1:0] mask,
    output logic [N-1:0] winner_c,
    output logic         valid_c,
    output logic [N-1:0] next_mask_c
);

    logic [N-1:0] masked;
    logic [N-1:0] pool;

    // Pick lowest set bit of the masked pool and the mask covering bits strictly above it.
    always_comb begin
        masked      = reqs & mask;
        pool        = (masked != '0) ? masked : reqs;
        winner_c    = pool & (~pool + N'(1));
        valid_c     = |reqs;
        next_mask_c = ~(winner_c | (winner_c - N'(1)));
    end

endmodule

// File: rtl/wrr_txn_arbiter.sv
// Weighted round-robin transaction-level arbiter.
// Optional: define WRR_TXN_ARB_WEIGHT_EN to build the per-turn credit counters;
// otherwise every transaction end releases the grant (plain round-robin).
module wrr_txn_arbiter
    import wrr_arb_pkg::*;
#(
    parameter int unsigned REQ_NUM = REQ_NUM_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned ID_W    = $clog2(REQ_NUM)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [REQ_NUM-1:0]       reqs,
    input  logic [REQ_NUM-1:0]       req_last,
    input  logic [REQ_NUM*CNT_W-1:0] weights,
    input  logic                     res_ready,
    output logic [REQ_NUM-1:0]       grants,
    output logic                     grant_valid,
    output logic [ID_W-1:0]          grant_id,
    output logic                     beat_fire
);

    arb_state_t         state_q, state_d;
    logic [REQ_NUM-1:0] mask_q, mask_d;
    logic [REQ_NUM-1:0] grants_d;
    logic               grant_valid_d;
    logic [ID_W-1:0]    grant_id_d;

    logic [REQ_NUM-1:0] pick_oh;
    logic               pick_valid;
    logic [REQ_NUM-1:0] pick_next_mask;
    logic [ID_W-1:0]    pick_id;
    logic               owner_req;
    logic               owner_last;

    rr_mask_pick #(.N(REQ_NUM)) u_pick (
        .reqs        (reqs),
        .mask        (mask_q),
        .winner_c    (pick_oh),
        .valid_c     (pick_valid),
        .next_mask_c (pick_next_mask)
    );

    assign pick_id    = ID_W'(onehot_to_bin(OH_MAX'(pick_oh)));
    assign owner_req  = |(reqs & grants);
    assign owner_last = |(req_last & grants);
    assign beat_fire  = grant_valid & owner_req & res_ready;

`ifdef WRR_TXN_ARB_WEIGHT_EN
    logic [CNT_W-1:0] credit_q, credit_d;
    logic [CNT_W-1:0] pick_w;

    // Weight of the requester being picked; sampled only at grant time.
    always_comb begin
        pick_w = '0;
        for (int i = 0; i < int'(REQ_NUM); i++) begin
            if (pick_oh[i]) pick_w = weights[i*int'(CNT_W) +: CNT_W];
        end
    end
`else
    logic unused_weights;
    assign unused_weights = ^weights;
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        mask_d        = mask_q;
        grants_d      = grants;
        grant_valid_d = grant_valid;
        grant_id_d    = grant_id;
`ifdef WRR_TXN_ARB_WEIGHT_EN
        credit_d      = credit_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    // Mask is only consulted in IDLE, so the post-turn mask is loaded at grant time.
                    grants_d      = pick_oh;
                    grant_valid_d = 1'b1;
                    grant_id_d    = pick_id;
                    mask_d        = pick_next_mask;
                    state_d       = BUSY;
`ifdef WRR_TXN_ARB_WEIGHT_EN
                    credit_d      = (pick_w == '0) ? '0 : pick_w - CNT_W'(1);
`endif
                end
            end
            BUSY: begin
                if (beat_fire && owner_last) begin
`ifdef WRR_TXN_ARB_WEIGHT_EN
                    if (credit_q != '0 && owner_req) begin
                        credit_d = credit_q - CNT_W'(1);
                    end else begin
                        grants_d      = '0;
                        grant_valid_d = 1'b0;
                        grant_id_d    = '0;
                        state_d       = IDLE;
                    end
`else
                    grants_d      = '0;
                    grant_valid_d = 1'b0;
                    grant_id_d    = '0;
                    state_d       = IDLE;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, mask, credit and registered grant outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mask_q      <= '1;
            grants      <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
`ifdef WRR_TXN_ARB_WEIGHT_EN
            credit_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            grants      <= grants_d;
            grant_valid <= grant_valid_d;
            grant_id    <= grant_id_d;
`ifdef WRR_TXN_ARB_WEIGHT_EN
            credit_q    <= credit_d;
`endif
        end
    end

endmodule

// File: tb/tb_wrr_txn_arbiter.sv
// Directed self-checking bench for wrr_txn_arbiter (REQ_NUM=8, CNT_W=4).
// Inputs change and outputs are sampled on the falling edge.
module tb_wrr_txn_arbiter;

    logic        clk;
    logic        rst_n;
    logic [7:0]  reqs;
    logic [7:0]  req_last;
    logic [31:0] weights;
    logic        res_ready;
    logic [7:0]  grants;
    logic        grant_valid;
    logic [2:0]  grant_id;
    logic        beat_fire;

    int n_cmp;
    int n_fail;

    wrr_txn_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .reqs        (reqs),
        .req_last    (req_last),
        .weights     (weights),
        .res_ready   (res_ready),
        .grants      (grants),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .beat_fire   (beat_fire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        reqs      = '0;
        req_last  = '0;
        res_ready = 1'b0;
        weights   = {8{4'd1}};
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        reqs      = 8'hFF;
        req_last  = 8'hFF;
        res_ready = 1'b1;
        weights   = {8{4'd1}};
        @(negedge clk);
        n_cmp++;
        if ({grants, grant_valid, grant_id, beat_fire} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_values: got g=%b v=%b id=%0d bf=%b expected all zero",
                     grants, grant_valid, grant_id, beat_fire);
        end
        rst_n = 1'b1;
        reqs  = 8'h08;
        @(negedge clk);
        n_cmp++;
        if ({grants, grant_valid, grant_id} !== {8'h08, 1'b1, 3'd3}) begin
            n_fail++;
            $display("FAIL first_grant_latency: got g=%b v=%b id=%0d expected g=00001000 v=1 id=3",
                     grants, grant_valid, grant_id);
        end
    endtask

    task automatic test_rotation();
        logic [7:0] exp_g  [5];
        logic [2:0] exp_id [5];
        exp_g  = '{8'h01, 8'h00, 8'h04, 8'h00, 8'h01};
        exp_id = '{3'd0, 3'd0, 3'd2, 3'd0, 3'd0};
        do_reset();
        reqs      = 8'h05;
        req_last  = 8'hFF;
        res_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({grants, grant_valid, grant_id, beat_fire} !==
                {exp_g[k], exp_g[k] != 8'h00, exp_id[k], exp_g[k] != 8'h00}) begin
                n_fail++;
                $display("FAIL rotation[%0d]: got g=%b v=%b id=%0d bf=%b expected g=%b id=%0d",
                         k, grants, grant_valid, grant_id, beat_fire, exp_g[k], exp_id[k]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_g  [5];
        logic [2:0] exp_id [5];
        exp_g  = '{8'h80, 8'h00, 8'h01, 8'h00, 8'h80};
        exp_id = '{3'd7, 3'd0, 3'd0, 3'd0, 3'd7};
        do_reset();
        reqs      = 8'h80;
        req_last  = 8'hFF;
        res_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({grants, grant_id, beat_fire} !== {exp_g[k], exp_id[k], exp_g[k] != 8'h00}) begin
                n_fail++;
                $display("FAIL wrap[%0d]: got g=%b id=%0d bf=%b expected g=%b id=%0d",
                         k, grants, grant_id, beat_fire, exp_g[k], exp_id[k]);
            end
            if (k == 0) reqs = 8'h81;
        end
    endtask

    task automatic test_weighted();
        logic [7:0] exp_g [7];
`ifdef WRR_TXN_ARB_WEIGHT_EN
        exp_g = '{8'h01, 8'h01, 8'h01, 8'h00, 8'h02, 8'h00, 8'h01};
`else
        exp_g = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h01, 8'h00, 8'h02};
`endif
        do_reset();
        weights[3:0] = 4'd3;
        weights[7:4] = 4'd1;
        reqs         = 8'h03;
        req_last     = 8'hFF;
        res_ready    = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({grants, beat_fire} !== {exp_g[k], exp_g[k] != 8'h00}) begin
                n_fail++;
                $display("FAIL weighted[%0d]: got g=%b bf=%b expected g=%b bf=%b",
                         k, grants, beat_fire, exp_g[k], exp_g[k] != 8'h00);
            end
        end
    endtask

    task automatic test_multibeat();
        logic [7:0] exp_g;
        logic [2:0] exp_id;
        logic       exp_bf;
        int         beats;
        beats = 0;
        do_reset();
        reqs      = 8'h04;
        req_last  = 8'h00;
        res_ready = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            exp_g  = (k <= 6) ? 8'h04 : 8'h00;
            exp_id = (k <= 6) ? 3'd2 : 3'd0;
            n_cmp++;
            if ({grants, grant_id} !== {exp_g, exp_id}) begin
                n_fail++;
                $display("FAIL multibeat_grant[%0d]: got g=%b id=%0d expected g=%b id=%0d",
                         k, grants, grant_id, exp_g, exp_id);
            end
            res_ready = !(k == 2 || k == 3);
            req_last  = (k == 6) ? 8'h04 : 8'h00;
            if (k == 7) reqs = 8'h00;
            #1;
            exp_bf = (k <= 6) && res_ready;
            n_cmp++;
            if (beat_fire !== exp_bf) begin
                n_fail++;
                $display("FAIL multibeat_fire[%0d]: got %b expected %b", k, beat_fire, exp_bf);
            end
            if (beat_fire) beats++;
        end
        n_cmp++;
        if (beats != 4) begin
            n_fail++;
            $display("FAIL multibeat_count: got %0d beats expected 4", beats);
        end
    endtask

    task automatic test_zero_weight();
        logic [7:0] exp_g  [4];
        logic [2:0] exp_id [4];
        exp_g  = '{8'h20, 8'h00, 8'h20, 8'h00};
        exp_id = '{3'd5, 3'd0, 3'd5, 3'd0};
        do_reset();
        weights[23:20] = 4'd0;
        reqs           = 8'h20;
        req_last       = 8'hFF;
        res_ready      = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({grants, grant_id} !== {exp_g[k], exp_id[k]}) begin
                n_fail++;
                $display("FAIL zero_weight[%0d]: got g=%b id=%0d expected g=%b id=%0d",
                         k, grants, grant_id, exp_g[k], exp_id[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        reqs      = 8'h10;
        req_last  = 8'h00;
        res_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({grants, grant_id} !== {8'h10, 3'd4}) begin
            n_fail++;
            $display("FAIL mid_owner: got g=%b id=%0d expected g=00010000 id=4", grants, grant_id);
        end
        reqs = 8'h11;
        @(negedge clk);
        n_cmp++;
        if ({grants, grant_id} !== {8'h10, 3'd4}) begin
            n_fail++;
            $display("FAIL busy_nonowner: got g=%b id=%0d expected g=00010000 id=4", grants, grant_id);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({grants, grant_valid, grant_id} !== 12'd0) begin
            n_fail++;
            $display("FAIL async_reset: got g=%b v=%b id=%0d expected all zero",
                     grants, grant_valid, grant_id);
        end
        @(negedge clk);
        reqs  = 8'h11;
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({grants, grant_id} !== {8'h01, 3'd0}) begin
            n_fail++;
            $display("FAIL post_reset_grant: got g=%b id=%0d expected g=00000001 id=0", grants, grant_id);
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        reqs      = '0;
        req_last  = '0;
        weights   = {8{4'd1}};
        res_ready = 1'b0;
        test_reset();
        test_rotation();
        test_wrap();
        test_weighted();
        test_multibeat();
        test_zero_weight();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
